// File: rtl/soc_ctrl_reg_mst.sv
// Command-driven register bus master: single write, single read and masked poll-until-match.
// Poll support is compiled in only when SOC_CTRL_REG_MST_POLL_EN is defined; otherwise op 10 is rejected like op 11.
`ifndef DHS_ADDRW
`define DHS_ADDRW 32
`endif
`ifndef DHS_DATAW
`define DHS_DATAW 32
`endif

module soc_ctrl_reg_mst #(
    parameter int ADDR_WIDTH = `DHS_ADDRW,
    parameter int DATA_WIDTH = `DHS_DATAW,
    parameter int POLL_MAX   = 1024,
    parameter int POLL_GAP   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [1:0]              cmd_op_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_data_i,
    input  logic [DATA_WIDTH-1:0]   cmd_mask_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_data_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_waddr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
    input  logic [1:0]              mem_wresp_i,
    output logic                    mem_re_o,
    output logic [ADDR_WIDTH-1:0]   mem_raddr_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic [1:0]              mem_rresp_i
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] RESP_OK = 2'b00;
`ifdef SOC_CTRL_REG_MST_POLL_EN
    localparam logic [1:0] OP_POLL = 2'b10;
    localparam int CNT_W = $clog2(POLL_MAX + 1);
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    typedef enum logic [2:0] {IDLE, WR, RD, POLL_RD, POLL_WAIT, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, WR, RD, RESP} state_t;
`endif

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    cmd_accept;
`ifdef SOC_CTRL_REG_MST_POLL_EN
    logic [DATA_WIDTH-1:0]   mask_q;
    logic [CNT_W-1:0]        poll_cnt_q, poll_cnt_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
`else
    logic                    unused_mask;
    assign unused_mask = ^cmd_mask_i;
`endif

    assign cmd_accept    = cmd_valid_i && (state_q == IDLE);
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_data_o    = rsp_data_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            data_q <= '0;
`ifdef SOC_CTRL_REG_MST_POLL_EN
            mask_q <= '0;
`endif
        end else if (cmd_accept) begin
            addr_q <= cmd_addr_i;
            data_q <= cmd_data_i;
`ifdef SOC_CTRL_REG_MST_POLL_EN
            mask_q <= cmd_mask_i;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
`ifdef SOC_CTRL_REG_MST_POLL_EN
            poll_cnt_q    <= '0;
            gap_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
`ifdef SOC_CTRL_REG_MST_POLL_EN
            poll_cnt_q    <= poll_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
`endif
        end
    end

    // Bus strobes are decoded from the state so address/data lines are zero outside their strobe cycle.
    always_comb begin
        state_d       = state_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
`ifdef SOC_CTRL_REG_MST_POLL_EN
        poll_cnt_d    = poll_cnt_q;
        gap_cnt_d     = gap_cnt_q;
`endif
        cmd_ready_o   = 1'b0;
        mem_we_o      = 1'b0;
        mem_waddr_o   = '0;
        mem_wdata_o   = '0;
        mem_wstrb_o   = '0;
        mem_re_o      = 1'b0;
        mem_raddr_o   = '0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    rsp_data_d    = '0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    case (cmd_op_i)
                        OP_WR: state_d = WR;
                        OP_RD: state_d = RD;
`ifdef SOC_CTRL_REG_MST_POLL_EN
                        OP_POLL: begin
                            state_d    = POLL_RD;
                            poll_cnt_d = CNT_W'(1);
                        end
`endif
                        default: begin
                            state_d   = RESP;
                            rsp_err_d = 1'b1;
                        end
                    endcase
                end
            end
            WR: begin
                mem_we_o    = 1'b1;
                mem_waddr_o = addr_q;
                mem_wdata_o = data_q;
                mem_wstrb_o = {STRB_W{1'b1}};
                rsp_err_d   = (mem_wresp_i != RESP_OK);
                state_d     = RESP;
            end
            RD: begin
                mem_re_o    = 1'b1;
                mem_raddr_o = addr_q;
                rsp_err_d   = (mem_rresp_i != RESP_OK);
                rsp_data_d  = (mem_rresp_i == RESP_OK) ? mem_rdata_i : '0;
                state_d     = RESP;
            end
`ifdef SOC_CTRL_REG_MST_POLL_EN
            POLL_RD: begin
                mem_re_o    = 1'b1;
                mem_raddr_o = addr_q;
                if (mem_rresp_i != RESP_OK) begin
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else if ((mem_rdata_i & mask_q) == (data_q & mask_q)) begin
                    rsp_data_d = mem_rdata_i;
                    state_d    = RESP;
                end else if (poll_cnt_q == CNT_W'(POLL_MAX)) begin
                    rsp_data_d    = mem_rdata_i;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    poll_cnt_d = poll_cnt_q + CNT_W'(1);
                    gap_cnt_d  = GAP_W'(POLL_GAP - 1);
                    state_d    = POLL_WAIT;
                end
            end
            POLL_WAIT: begin
                if (gap_cnt_q == '0) state_d = POLL_RD;
                else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
`endif
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_soc_ctrl_reg_mst.sv
// Directed bench for soc_ctrl_reg_mst: scoreboarded responses plus a bus monitor and a combinational responder.
// Poll scenarios run when SOC_CTRL_REG_MST_POLL_EN is defined; otherwise op 10 is checked as a rejected command.
module tb_soc_ctrl_reg_mst;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int PMAX = 8;
    localparam int PGAP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [DW-1:0] cmd_mask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic [1:0]    wresp = 2'b00;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    rresp = 2'b00;

    logic [DW-1:0] rd_base = '0;
    logic [DW-1:0] rd_hit = '0;
    int            rd_count = 0;
    int            hit_at = 0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int viol = 0;
    bit mon_en = 1'b0;
    int we_q[$];
    int re_q[$];
    logic [AW-1:0] last_waddr = '0;
    logic [DW-1:0] last_wdata = '0;
    logic [SW-1:0] last_wstrb = '0;
    logic [AW-1:0] last_raddr = '0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
        logic          to;
        logic [31:0]   lat;
    } exp_t;
    exp_t  sb[$];
    string tag_q[$];

    soc_ctrl_reg_mst #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .POLL_MAX  (PMAX),
        .POLL_GAP  (PGAP)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_addr_i   (cmd_addr),
        .cmd_data_i   (cmd_data),
        .cmd_mask_i   (cmd_mask),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_err_o    (rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .mem_we_o     (mem_we),
        .mem_waddr_o  (mem_waddr),
        .mem_wdata_o  (mem_wdata),
        .mem_wstrb_o  (mem_wstrb),
        .mem_wresp_i  (wresp),
        .mem_re_o     (mem_re),
        .mem_raddr_o  (mem_raddr),
        .mem_rdata_i  (mem_rdata),
        .mem_rresp_i  (rresp)
    );

    always #5 clk = ~clk;

    // Responder switches from rd_base to rd_hit once hit_at reads have completed.
    assign mem_rdata = (rd_count >= hit_at) ? rd_hit : rd_base;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_re) rd_count <= rd_count + 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we) begin
                we_q.push_back(cyc);
                last_waddr = mem_waddr;
                last_wdata = mem_wdata;
                last_wstrb = mem_wstrb;
            end
            if (mem_re) begin
                re_q.push_back(cyc);
                last_raddr = mem_raddr;
            end
            if (mem_we && mem_re) viol++;
            if (!mem_we && (mem_waddr != '0 || mem_wdata != '0 || mem_wstrb != '0)) viol++;
            if (!mem_re && mem_raddr != '0) viol++;
        end
    end

    task automatic compare(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic setResponder(input logic [DW-1:0] base, input logic [DW-1:0] hit, input int reads_before_hit);
        rd_base = base;
        rd_hit  = hit;
        hit_at  = rd_count + reads_before_hit;
        we_q.delete();
        re_q.delete();
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [DW-1:0] mask,
                                 input bit expect_rsp, input logic [DW-1:0] e_data,
                                 input logic e_err, input logic e_to, input int e_lat, input string tag);
        int guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_mask  = mask;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) compare({tag, "_accept"}, 64'(cmd_ready), 64'd1);
        acc_cyc = cyc + 1;
        if (expect_rsp) begin
            sb.push_back('{data: e_data, err: e_err, to: e_to, lat: 32'(e_lat)});
            tag_q.push_back(tag);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = '0;
        cmd_data  = '0;
        cmd_mask  = '0;
    endtask

    task automatic checkOutput(input int hold);
        exp_t          e;
        string         tag;
        int            guard = 0;
        bit            stable = 1'b1;
        logic [DW+1:0] snap;
        while (!rsp_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() == 0) begin
            compare("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e   = sb.pop_front();
        tag = tag_q.pop_front();
        compare({tag, "_valid"},   64'(rsp_valid), 64'd1);
        compare({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(e.lat));
        compare({tag, "_data"},    64'(rsp_data), 64'(e.data));
        compare({tag, "_err"},     64'(rsp_err), 64'(e.err));
        compare({tag, "_timeout"}, 64'(rsp_timeout), 64'(e.to));
        snap = {rsp_data, rsp_err, rsp_timeout};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if ({rsp_data, rsp_err, rsp_timeout} !== snap || rsp_valid !== 1'b1 || cmd_ready !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0) compare({tag, "_hold"}, 64'(stable), 64'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        compare({tag, "_idle"}, 64'({rsp_valid, cmd_ready}), 64'd1);
    endtask

    initial begin
        int n;
        bit seen;
        $display("[TB] start");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compare("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        compare("reset_rsp", 64'({rsp_valid, rsp_err, rsp_timeout, rsp_data}), 64'd0);
        compare("reset_mem", 64'({mem_we, mem_re, mem_waddr, mem_raddr}), 64'd0);
        mon_en = 1'b1;

        setResponder(32'h0, 32'h0, 0);
        applyStimulus(2'b00, 16'h0040, 32'hDEADBEEF, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1, "write");
        checkOutput(0);
        compare("write_count",  64'(we_q.size()), 64'd1);
        compare("write_cycle",  64'(we_q[0]), 64'(acc_cyc));
        compare("write_addr",   64'(last_waddr), 64'h40);
        compare("write_data",   64'(last_wdata), 64'hDEADBEEF);
        compare("write_strb",   64'(last_wstrb), 64'hF);
        compare("write_noread", 64'(re_q.size()), 64'd0);

        wresp = 2'b10;
        setResponder(32'h0, 32'h0, 0);
        applyStimulus(2'b00, 16'h0044, 32'h00000001, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1, "write_slverr");
        checkOutput(0);
        wresp = 2'b00;

        setResponder(32'h12345678, 32'h12345678, 0);
        applyStimulus(2'b01, 16'h0080, 32'h0, 32'h0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1, "read_bp");
        checkOutput(5);
        compare("read_count", 64'(re_q.size()), 64'd1);
        compare("read_cycle", 64'(re_q[0]), 64'(acc_cyc));
        compare("read_addr",  64'(last_raddr), 64'h80);

        rresp = 2'b10;
        setResponder(32'hA5A5A5A5, 32'hA5A5A5A5, 0);
        applyStimulus(2'b01, 16'h01FC, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1, "read_err");
        checkOutput(0);
        rresp = 2'b00;

        setResponder(32'h0, 32'h0, 0);
        applyStimulus(2'b11, 16'h0010, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 0, "op11");
        checkOutput(0);
        compare("op11_nobus", 64'(we_q.size() + re_q.size()), 64'd0);

`ifdef SOC_CTRL_REG_MST_POLL_EN
        setResponder(32'h000000A5, 32'h000100A5, 2);
        applyStimulus(2'b10, 16'h0100, 32'h00010000, 32'h00010000, 1'b1, 32'h000100A5, 1'b0, 1'b0,
                      2 * (PGAP + 1) + 1, "poll_match");
        checkOutput(0);
        compare("poll_match_reads", 64'(re_q.size()), 64'd3);
        compare("poll_match_gap1",  64'(re_q[1] - re_q[0]), 64'(PGAP + 1));
        compare("poll_match_gap2",  64'(re_q[2] - re_q[1]), 64'(PGAP + 1));
        compare("poll_match_addr",  64'(last_raddr), 64'h100);

        setResponder(32'h0000CAFE, 32'h0000CAFE, 0);
        applyStimulus(2'b10, 16'h0104, 32'h00001234, 32'h0, 1'b1, 32'h0000CAFE, 1'b0, 1'b0, 1, "poll_mask0");
        checkOutput(0);
        compare("poll_mask0_reads", 64'(re_q.size()), 64'd1);

        rresp = 2'b10;
        setResponder(32'h00010000, 32'h00010000, 0);
        applyStimulus(2'b10, 16'h0108, 32'h00010000, 32'h00010000, 1'b1, 32'h0, 1'b1, 1'b0, 1, "poll_err");
        checkOutput(0);
        compare("poll_err_reads", 64'(re_q.size()), 64'd1);
        rresp = 2'b00;

        setResponder(32'h0, 32'hFFFFFFFF, 1000);
        applyStimulus(2'b10, 16'h010C, 32'h00000001, 32'h00000001, 1'b1, 32'h0, 1'b1, 1'b1,
                      PMAX * (PGAP + 1) - PGAP, "poll_timeout");
        checkOutput(0);
        compare("poll_timeout_reads", 64'(re_q.size()), 64'(PMAX));
        compare("poll_timeout_span",  64'(re_q[PMAX-1] - re_q[0]), 64'((PMAX - 1) * (PGAP + 1)));

        setResponder(32'h0, 32'hFFFFFFFF, 1000);
        applyStimulus(2'b10, 16'h0110, 32'h00000001, 32'h00000001, 1'b0, 32'h0, 1'b0, 1'b0, 0, "poll_reset");
        n = 0;
        while (re_q.size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        compare("poll_reset_started", 64'(re_q.size() >= 2), 64'd1);
`else
        setResponder(32'h0, 32'h0, 0);
        applyStimulus(2'b10, 16'h0100, 32'h00010000, 32'h00010000, 1'b1, 32'h0, 1'b1, 1'b0, 0, "op10_off");
        checkOutput(0);
        compare("op10_off_nobus", 64'(we_q.size() + re_q.size()), 64'd0);

        setResponder(32'h0, 32'h0, 0);
        applyStimulus(2'b11, 16'h0110, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 0, "cmd_reset");
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = re_q.size();
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        compare("abort_no_rsp",    64'(seen), 64'd0);
        compare("abort_no_reads",  64'(re_q.size()), 64'(n));
        compare("abort_idle",      64'(cmd_ready), 64'd1);
        compare("mem_strobe_rules", 64'(viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
